prog_clock_divider: RTL and testbench

//  Runtime-programmable clock/tick generator; successor to the fixed divide-by-100 divider.

---
 rtl/prog_clock_divider_pkg.sv | 11 +
 rtl/prog_clock_divider_if.sv | 15 +
 rtl/prog_clock_divider.sv | 49 ++++
 tb/tb_prog_clock_divider.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_clock_divider_pkg.sv
// prog_clock_divider_pkg: shared widths, reset defaults and divisor clamp for the clock divider
// Holds CNT_W, the after-reset period/duty and the minimum legal period.
package prog_clock_divider_pkg;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(100);
  localparam logic [CNT_W-1:0] DEF_DUTY = CNT_W'(50);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return d < MIN_DIV ? MIN_DIV : d;
  endfunction
endpackage

// File: rtl/prog_clock_divider_if.sv
// prog_clock_divider_if: control/status bundle of the programmable clock divider
// Ports: i_enable run gate, i_load shadow-capture strobe, i_div period, i_duty high cycles,
//        o_clk divided waveform, o_tick period-start pulse, o_pending shadow waiting to apply.
interface prog_clock_divider_if;
  import prog_clock_divider_pkg::*;
  logic i_enable;
  logic i_load;
  logic [CNT_W-1:0] i_div;
  logic [CNT_W-1:0] i_duty;
  logic o_clk;
  logic o_tick;
  logic o_pending;
  modport master (output i_enable, i_load, i_div, i_duty, input o_clk, o_tick, o_pending);
  modport slave (input i_enable, i_load, i_div, i_duty, output o_clk, o_tick, o_pending);
endinterface

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: runtime-programmable divided clock-enable with period tick and shadowed updates
// Ports: i_clk system clock, i_reset async active-high reset, bus (slave) control/status bundle.
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEFAULT_DIV = DEF_DIV,
  parameter logic [CNT_W-1:0] DEFAULT_DUTY = DEF_DUTY
) (
  input logic i_clk,
  input logic i_reset,
  prog_clock_divider_if.slave bus
);
  logic [CNT_W-1:0] cnt, act_div, act_duty, sh_div, sh_duty, cnt_nx, duty_nx;
  logic idle, wrap, apply;
  // Count 0 while running always carries o_tick, so cnt==0 without a tick means "not running".
  always_comb begin
    idle = cnt == '0 && !bus.o_tick;
    wrap = !idle && cnt == act_div - CNT_W'(1);
    apply = bus.o_pending && (idle || wrap || !bus.i_enable);
    cnt_nx = (!bus.i_enable || idle || wrap) ? '0 : cnt + CNT_W'(1);
    duty_nx = apply ? sh_duty : act_duty;
  end
  // Outputs are computed from the next count so they line up with cnt in the same cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
      act_div <= clamp_div(DEFAULT_DIV);
      act_duty <= DEFAULT_DUTY;
      sh_div <= clamp_div(DEFAULT_DIV);
      sh_duty <= DEFAULT_DUTY;
      bus.o_pending <= 1'b0;
      bus.o_clk <= 1'b0;
      bus.o_tick <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      bus.o_tick <= bus.i_enable && cnt_nx == '0;
      bus.o_clk <= bus.i_enable && cnt_nx < duty_nx;
      if (apply) begin
        act_div <= sh_div;
        act_duty <= sh_duty;
      end
      if (bus.i_load) begin
        sh_div <= clamp_div(bus.i_div);
        sh_duty <= bus.i_duty;
      end
      bus.o_pending <= bus.i_load || (bus.o_pending && !apply);
    end
  end
endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: directed self-checking bench for prog_clock_divider
module tb_prog_clock_divider;
  import prog_clock_divider_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  prog_clock_divider_if bus();
  prog_clock_divider dut (.i_clk(clk), .i_reset(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] u);
    bus.i_load = 1'b1;
    bus.i_div = d;
    bus.i_duty = u;
  endtask
  task automatic test_reset();
    bus.i_enable = 1'b0;
    bus.i_load = 1'b0;
    bus.i_div = '0;
    bus.i_duty = '0;
    #2 rst = 1'b1;
    #2;
    total++;
    if ({bus.o_clk, bus.o_tick, bus.o_pending} !== 3'b000) begin
      bad++;
      $display("FAIL reset outputs clk/tick/pend=%b want 000", {bus.o_clk, bus.o_tick, bus.o_pending});
    end
    step();
    rst = 1'b0;
    bus.i_enable = 1'b1;
    step();
  endtask
  task automatic test_default();
    for (int k = 0; k < 200; k++) begin
      total++;
      if (bus.o_tick !== (k % 100 == 0) || bus.o_clk !== (k % 100 < 50) || bus.o_pending !== 1'b0) begin
        bad++;
        $display("FAIL default k=%0d tick=%b clk=%b pend=%b want tick=%b clk=%b pend=0", k, bus.o_tick, bus.o_clk, bus.o_pending, k % 100 == 0, k % 100 < 50);
      end
      step();
    end
  endtask
  task automatic test_load();
    repeat (40) step();
    load(10, 3);
    step();
    bus.i_load = 1'b0;
    for (int k = 41; k < 100; k++) begin
      total++;
      if (bus.o_pending !== 1'b1 || bus.o_clk !== (k < 50) || bus.o_tick !== 1'b0) begin
        bad++;
        $display("FAIL load_wait k=%0d pend=%b clk=%b tick=%b want pend=1 clk=%b tick=0", k, bus.o_pending, bus.o_clk, bus.o_tick, k < 50);
      end
      step();
    end
    for (int k = 0; k < 20; k++) begin
      total++;
      if (bus.o_tick !== (k % 10 == 0) || bus.o_clk !== (k % 10 < 3) || bus.o_pending !== 1'b0) begin
        bad++;
        $display("FAIL load_apply k=%0d tick=%b clk=%b pend=%b want tick=%b clk=%b pend=0", k, bus.o_tick, bus.o_clk, bus.o_pending, k % 10 == 0, k % 10 < 3);
      end
      step();
    end
  endtask
  task automatic test_clamp();
    load(1, 1);
    step();
    bus.i_load = 1'b0;
    repeat (9) step();
    for (int k = 0; k < 6; k++) begin
      total++;
      if (bus.o_tick !== (k % 2 == 0) || bus.o_clk !== (k % 2 == 0)) begin
        bad++;
        $display("FAIL clamp_p2 k=%0d tick=%b clk=%b want tick=%b clk=%b", k, bus.o_tick, bus.o_clk, k % 2 == 0, k % 2 == 0);
      end
      step();
    end
    load(1, 0);
    step();
    bus.i_load = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      total++;
      if (bus.o_tick !== (k % 2 == 0) || bus.o_clk !== 1'b0) begin
        bad++;
        $display("FAIL duty_zero k=%0d tick=%b clk=%b want tick=%b clk=0", k, bus.o_tick, bus.o_clk, k % 2 == 0);
      end
      step();
    end
    load(10, 20);
    step();
    bus.i_load = 1'b0;
    step();
    for (int k = 0; k < 20; k++) begin
      total++;
      if (bus.o_tick !== (k % 10 == 0) || bus.o_clk !== 1'b1) begin
        bad++;
        $display("FAIL duty_full k=%0d tick=%b clk=%b want tick=%b clk=1", k, bus.o_tick, bus.o_clk, k % 10 == 0);
      end
      step();
    end
  endtask
  task automatic test_back_to_back();
    load(20, 5);
    step();
    load(30, 5);
    step();
    bus.i_load = 1'b0;
    total++;
    if (bus.o_pending !== 1'b1) begin
      bad++;
      $display("FAIL b2b_pending got=%b want=1", bus.o_pending);
    end
    repeat (8) step();
    for (int k = 0; k < 60; k++) begin
      total++;
      if (bus.o_tick !== (k % 30 == 0) || bus.o_clk !== (k % 30 < 5) || bus.o_pending !== 1'b0) begin
        bad++;
        $display("FAIL b2b_last k=%0d tick=%b clk=%b pend=%b want tick=%b clk=%b pend=0", k, bus.o_tick, bus.o_clk, bus.o_pending, k % 30 == 0, k % 30 < 5);
      end
      step();
    end
  endtask
  task automatic test_coincident();
    load(4, 1);
    step();
    bus.i_load = 1'b0;
    repeat (28) step();
    load(6, 2);
    step();
    bus.i_load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (bus.o_tick !== (k == 0) || bus.o_clk !== (k < 1) || bus.o_pending !== 1'b1) begin
        bad++;
        $display("FAIL coinc_old k=%0d tick=%b clk=%b pend=%b want tick=%b clk=%b pend=1", k, bus.o_tick, bus.o_clk, bus.o_pending, k == 0, k < 1);
      end
      step();
    end
    for (int k = 0; k < 12; k++) begin
      total++;
      if (bus.o_tick !== (k % 6 == 0) || bus.o_clk !== (k % 6 < 2) || bus.o_pending !== 1'b0) begin
        bad++;
        $display("FAIL coinc_new k=%0d tick=%b clk=%b pend=%b want tick=%b clk=%b pend=0", k, bus.o_tick, bus.o_clk, bus.o_pending, k % 6 == 0, k % 6 < 2);
      end
      step();
    end
  endtask
  task automatic test_idle();
    repeat (5) step();
    bus.i_enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      total++;
      if (bus.o_clk !== 1'b0 || bus.o_tick !== 1'b0) begin
        bad++;
        $display("FAIL idle_out i=%0d clk=%b tick=%b want 0 0", i, bus.o_clk, bus.o_tick);
      end
      if (i == 2) load(8, 3);
      if (i == 3) begin
        bus.i_load = 1'b0;
        total++;
        if (bus.o_pending !== 1'b1) begin
          bad++;
          $display("FAIL idle_load_pend got=%b want=1", bus.o_pending);
        end
      end
      if (i == 4) begin
        total++;
        if (bus.o_pending !== 1'b0) begin
          bad++;
          $display("FAIL idle_apply_pend got=%b want=0", bus.o_pending);
        end
      end
    end
    bus.i_enable = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      total++;
      if (bus.o_tick !== (k % 8 == 0) || bus.o_clk !== (k % 8 < 3)) begin
        bad++;
        $display("FAIL reenable k=%0d tick=%b clk=%b want tick=%b clk=%b", k, bus.o_tick, bus.o_clk, k % 8 == 0, k % 8 < 3);
      end
      step();
    end
  endtask
  task automatic test_reset_mid();
    step();
    load(4, 1);
    step();
    bus.i_load = 1'b0;
    step();
    total++;
    if (bus.o_pending !== 1'b1 || bus.o_clk !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset pend=%b clk=%b want pend=1 clk=0", bus.o_pending, bus.o_clk);
    end
    repeat (5) step();
    rst = 1'b1;
    #1;
    total++;
    if ({bus.o_clk, bus.o_tick, bus.o_pending} !== 3'b000) begin
      bad++;
      $display("FAIL mid_reset clk/tick/pend=%b want 000", {bus.o_clk, bus.o_tick, bus.o_pending});
    end
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 100; k++) begin
      total++;
      if (bus.o_tick !== (k == 0) || bus.o_clk !== (k < 50) || bus.o_pending !== 1'b0) begin
        bad++;
        $display("FAIL post_reset k=%0d tick=%b clk=%b pend=%b want tick=%b clk=%b pend=0", k, bus.o_tick, bus.o_clk, bus.o_pending, k == 0, k < 50);
      end
      step();
    end
  endtask
  initial begin
    test_reset();
    test_default();
    test_load();
    test_clamp();
    test_back_to_back();
    test_coincident();
    test_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
